// File: rtl/mem_pkg.sv
// Shared definitions for the load/store initiator: funct3 codes, FSM states
// and the default byte-address width.
package mem_pkg;

  localparam int DEFAULT_ADDR_W = 32;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the word-wide memory and the core: load
// extraction with sign/zero extension, and sub-word store merging.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_word,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_word[{byte_off, 3'b000} +: 8];
    half_sel = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

    load_word = '0;
    case (funct3)
      F3_B:    load_word = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_word = {24'd0, byte_sel};
      F3_H:    load_word = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_word = {16'd0, half_sel};
      F3_W:    load_word = rd_word;
      default: load_word = '0;
    endcase

    // Sub-word stores keep the untouched lanes of the word read in RD
    store_word = rd_word;
    case (funct3)
      F3_B: store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (byte_off[1]) store_word[31:16] = wdata[15:0];
        else             store_word[15:0]  = wdata[15:0];
      end
      F3_W:    store_word = wdata;
      default: store_word = rd_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: one RV32I request at a time, read-modify-write for
// sub-word stores, aligned and extended load data with a one-cycle response.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = mem_pkg::DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_dout
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic              write_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rd_word;
  logic              err_q;
  logic              illegal, misaligned, accept;
  logic [31:0]       load_word, store_word;

  mem_lane_align u_align (
    .funct3     (f3_q),
    .byte_off   (addr_q[1:0]),
    .rd_word    (rd_word),
    .wdata      (wdata_q),
    .load_word  (load_word),
    .store_word (store_word)
  );

  always_comb begin
    accept = (state == S_IDLE) && req_valid;
    if (req_write) illegal = (req_funct3 > F3_W);
    else           illegal = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    case (req_funct3)
      F3_H, F3_HU: misaligned = req_addr[0];
      F3_W:        misaligned = |req_addr[1:0];
      default:     misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rd_word <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        addr_q  <= req_addr;
        f3_q    <= req_funct3;
        write_q <= req_write;
        wdata_q <= req_wdata;
        err_q   <= illegal | misaligned;
      end
      if (state == S_RD) rd_word <= mem_dout;
    end
  end

  // Full-word stores skip the read; sub-word stores read first, then merge
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (illegal || misaligned)         next_state = S_RESP;
          else if (!req_write)               next_state = S_RD;
          else if (req_funct3 == F3_W)       next_state = S_WR;
          else                               next_state = S_RD;
        end
      end
      S_RD:    next_state = write_q ? S_WR : S_RESP;
      S_WR:    next_state = S_RESP;
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Strobes are gated by reset so an interrupted RMW never reaches memory
  always_comb begin
    req_ready  = (state == S_IDLE);
    mem_read   = (state == S_RD) && !reset;
    mem_write  = (state == S_WR) && !reset;
    mem_addr   = '0;
    mem_din    = '0;
    if (state == S_RD || state == S_WR) mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    if (state == S_WR) mem_din = store_word;
    resp_valid = (state == S_RESP);
    resp_err   = (state == S_RESP) && err_q;
    resp_rdata = (state == S_RESP && !err_q && !write_q) ? load_word : '0;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator sitting between the multi-cycle core datapath and the word-addressed data `Memory`. It accepts one RV32I load or store request at a time and sequences the memory's `mem_read`/`mem_write` strobes. Sub-word stores are performed as read-modify-write. Load data is lane-aligned and sign/zero-extended before being returned with a one-cycle response strobe.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width on both sides.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: core request present.
- `req_ready` out 1: unit can accept a request; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion strobe.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned address or illegal funct3; valid with `resp_valid`.
- `mem_addr` out ADDR_W: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_din` out 32: write data to memory.
- `mem_read` out 1: read strobe.
- `mem_write` out 1: write strobe.
- `mem_dout` in 32: combinational read data from memory.

## Operation
- FSM states: IDLE, RD, WR, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch addr, funct3, write flag and wdata, then classify the request:
  - Illegal funct3 (load 3/6/7; store ≥3) -> RESP with error.
  - Misaligned (H: addr[0]≠0; W: addr[1:0]≠0) -> RESP with error.
  - Load -> RD.
  - SW -> WR.
  - SB/SH -> RD.
- RD:
  - Drive `mem_read`=1 and `mem_addr`.
  - Sample `mem_dout` into word register `rd_word` at the end of the cycle.
  - Load -> RESP. Sub-word store -> WR.
- WR:
  - Drive `mem_write`=1 and `mem_din`.
  - SW: `mem_din` = wdata.
  - SB: `rd_word` with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: `rd_word` with halfword lane addr[1] replaced by wdata[15:0].
  - -> RESP.
- RESP:
  - `resp_valid`=1 for one cycle.
  - Load: `resp_rdata` = lane of `rd_word` selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
  - -> IDLE.
- `mem_read` and `mem_write` are never high together. Both are 0 outside RD/WR, and both are gated low while `reset`=1.
- `mem_addr` = 0 and `mem_din` = 0 when not in RD/WR.

## Timing
- Reset values: state IDLE; `req_ready`=1; `resp_valid`, `resp_err`, `mem_read`, `mem_write` = 0; `resp_rdata`, `mem_addr`, `mem_din` = 0; latched request and `rd_word` = 0.
- Accept at edge N (request seen in IDLE):
  - Load: RD in cycle N+1; `resp_valid` in cycle N+2.
  - SW: WR in N+1; memory updated at edge ending N+1; `resp_valid` in N+2.
  - SB/SH: RD N+1, WR N+2, `resp_valid` N+3.
  - Error: `resp_valid`+`resp_err` in N+1; no memory strobe issued.
- Back-to-back: a new request can be accepted in the cycle after RESP (IDLE). Minimum load-to-load spacing is 3 cycles.
- `req_valid` outside IDLE is ignored and not queued.
- Reset mid-operation (any state):
  - Strobes drop immediately via gating.
  - Next edge returns to IDLE with no response.
  - A partial RMW write never occurs.
- Request inputs are sampled only at the accept edge; later changes do not affect the transaction in flight.

## Structure
- Shared package `mem_pkg`:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum (S_IDLE, S_RD, S_WR, S_RESP).
  - `ADDR_W` default.
- One sub-module `mem_lane_align` (combinational): load extraction/extension and store merge, keyed by funct3 and addr[1:0].
- The FSM and registers stay in `mem_access_unit`.

## Test plan
- LW addr 0x10, memory word 4 = 0x8765_4321 -> `mem_read` in N+1 with `mem_addr`=0x10; `resp_rdata`=0x8765_4321, `resp_err`=0 in N+2.
- LB addr 0x13 and LBU addr 0x13 on the same word -> `resp_rdata` 0xFFFF_FF87 and 0x0000_0087 respectively.
- SB 0xAB to addr 0x11, old word 0x1122_3344 -> RD in N+1, WR in N+2 with `mem_din`=0x1122_AB44, `resp_valid` in N+3; a following LW returns 0x1122_AB44.
- SH to addr 0x11, and LW to addr 0x0E -> `resp_err`=1 in N+1, zero memory strobes, memory unchanged.
- Illegal load funct3=3 at addr 0x20 -> `resp_err`=1, `resp_rdata`=0, no `mem_read`.
- `reset` asserted during WR of an SH -> `mem_write` low that cycle, state IDLE after the edge, target word unchanged, no `resp_valid`.
